// File: rtl/morse_key_controller_pkg.sv
// Shared types and constants for the Morse key sequencer (package morse_ctrl_pkg).
package morse_ctrl_pkg;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StPress,
    StGap,
    StLatch,
    StOut
  } ctrl_state_e;

  localparam logic SYM_DOT  = 1'b1;
  localparam logic SYM_DASH = 1'b0;

  localparam int unsigned MAX_SYMBOLS = 5;
  localparam logic [7:0]  ASCII_NUL   = 8'h00;

endpackage

// File: rtl/morse_key_controller_if.sv
// Decoder-side control and character output stream of the Morse key sequencer.
interface morse_key_controller_if;

  logic       dec_step;
  logic       dec_in;
  logic       dec_clear;
  logic [7:0] dec_char;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (
    output dec_step, dec_in, dec_clear, char_valid, char_data,
    input  dec_char, char_ready
  );

  modport slave (
    input  dec_step, dec_in, dec_clear, char_valid, char_data,
    output dec_char, char_ready
  );

endinterface

// File: rtl/morse_tick_gen.sv
// Prescaler: one-cycle tick every TickDiv clocks, phase reset by restart_i.
module morse_tick_gen #(
  parameter int unsigned TickDiv = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = 1'b0;
    cnt_d  = cnt_q + 1'b1;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      tick_o = 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_key_controller.sv
// Times key presses/gaps, steps the Morse decoder and hands out decoded letters.
// Optional MORSE_CTRL_ERR_CNT_EN adds a saturating count of discarded letters.
module morse_key_controller
  import morse_ctrl_pkg::*;
#(
  parameter int unsigned TickDiv   = 1000,
  parameter int unsigned DotMax    = 3,
  parameter int unsigned LetterGap = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   key_i,
  morse_key_controller_if.master ctrl
`ifdef MORSE_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]             err_count_o
`endif
);

  localparam int unsigned PressW = $clog2(DotMax + 2);
  localparam int unsigned GapW   = (LetterGap > 0) ? $clog2(LetterGap + 1) : 1;
  localparam int unsigned SymW   = $clog2(MAX_SYMBOLS + 1);

  localparam logic [PressW-1:0] PressSat = PressW'(DotMax + 1);
  localparam logic [PressW-1:0] DotLim   = PressW'(DotMax);
  localparam logic [GapW-1:0]   GapEnd   = GapW'(LetterGap);
  localparam logic [SymW-1:0]   SymMax   = SymW'(MAX_SYMBOLS);

  ctrl_state_e       state_q, state_d;
  logic [PressW-1:0] press_cnt_q, press_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [SymW-1:0]   sym_cnt_q, sym_cnt_d;
  logic              ovf_q, ovf_d;
  logic              key_q;
  logic              dec_step_q, dec_step_d;
  logic              dec_in_q, dec_in_d;
  logic              dec_clear_q, dec_clear_d;
  logic              char_valid_q, char_valid_d;
  logic [7:0]        char_data_q, char_data_d;
  logic              restart;
  logic              tick;
  logic              key_rise, key_fall;

  assign key_rise = key_i & ~key_q;
  assign key_fall = ~key_i & key_q;

  morse_tick_gen #(
    .TickDiv (TickDiv)
  ) u_tick_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d      = state_q;
    press_cnt_d  = press_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    ovf_d        = ovf_q;
    dec_step_d   = 1'b0;
    dec_in_d     = dec_in_q;
    dec_clear_d  = 1'b0;
    char_valid_d = char_valid_q;
    char_data_d  = char_data_q;
    restart      = 1'b0;

    unique case (state_q)
      // Every entry into CLEAR pre-arms dec_clear, so its pulse lands in the first CLEAR cycle.
      StClear: begin
        sym_cnt_d = '0;
        ovf_d     = 1'b0;
        if (dec_clear_q) begin
          state_d = StIdle;
        end else begin
          dec_clear_d = 1'b1;
        end
      end
      StIdle: begin
        if (key_rise) begin
          state_d     = StPress;
          press_cnt_d = '0;
          restart     = 1'b1;
        end
      end
      StPress: begin
        if (key_fall) begin
          restart   = 1'b1;
          gap_cnt_d = '0;
          if (press_cnt_q == '0) begin
            state_d = (sym_cnt_q == '0) ? StIdle : StGap;
          end else begin
            state_d = StGap;
            if (sym_cnt_q < SymMax) begin
              dec_step_d = 1'b1;
              dec_in_d   = (press_cnt_q <= DotLim) ? SYM_DOT : SYM_DASH;
              sym_cnt_d  = sym_cnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (tick && (press_cnt_q != PressSat)) begin
          press_cnt_d = press_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (key_rise) begin
          state_d     = StPress;
          press_cnt_d = '0;
          restart     = 1'b1;
        end else if (gap_cnt_q == GapEnd) begin
          state_d = StLatch;
        end else if (tick) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      StLatch: begin
        if (!ovf_q && (ctrl.dec_char != ASCII_NUL)) begin
          char_data_d  = ctrl.dec_char;
          char_valid_d = 1'b1;
          state_d      = StOut;
        end else begin
          state_d     = StClear;
          dec_clear_d = 1'b1;
        end
      end
      StOut: begin
        if (ctrl.char_ready) begin
          char_valid_d = 1'b0;
          state_d      = StClear;
          dec_clear_d  = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StClear;
      press_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      key_q        <= 1'b0;
      dec_step_q   <= 1'b0;
      dec_in_q     <= 1'b0;
      dec_clear_q  <= 1'b0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      press_cnt_q  <= press_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      ovf_q        <= ovf_d;
      key_q        <= key_i;
      dec_step_q   <= dec_step_d;
      dec_in_q     <= dec_in_d;
      dec_clear_q  <= dec_clear_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
    end
  end

  assign ctrl.dec_step   = dec_step_q;
  assign ctrl.dec_in     = dec_in_q;
  assign ctrl.dec_clear  = dec_clear_q;
  assign ctrl.char_valid = char_valid_q;
  assign ctrl.char_data  = char_data_q;

`ifdef MORSE_CTRL_ERR_CNT_EN
  logic       discard;
  logic [7:0] err_cnt_q;

  assign discard = (state_q == StLatch) && (ovf_q || (ctrl.dec_char == ASCII_NUL));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= 8'h00;
    end else if (discard && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_morse_key_controller.sv
// Directed bench for morse_key_controller with a small behavioural Morse decoder.
module tb_morse_key_controller;
  import morse_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  morse_key_controller_if bus ();

  morse_key_controller #(
    .TickDiv   (4),
    .DotMax    (2),
    .LetterGap (6)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .key_i  (key),
    .ctrl   (bus)
`ifdef MORSE_CTRL_ERR_CNT_EN
    ,
    .err_count_o (err_count)
`endif
  );

`ifndef MORSE_CTRL_ERR_CNT_EN
  assign err_count = 8'h00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural decoder: symbol history, newest symbol in bit 0 (1 = dot).
  logic [2:0] mlen;
  logic [4:0] mbits;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mlen  <= 3'd0;
      mbits <= 5'd0;
    end else if (bus.dec_clear) begin
      mlen  <= 3'd0;
      mbits <= 5'd0;
    end else if (bus.dec_step && (mlen < 3'd5)) begin
      mlen  <= mlen + 3'd1;
      mbits <= {mbits[3:0], bus.dec_in};
    end
  end

  always_comb begin
    bus.dec_char = 8'h00;
    case ({mlen, mbits})
      {3'd1, 5'b00001}: bus.dec_char = 8'h45;
      {3'd1, 5'b00000}: bus.dec_char = 8'h54;
      {3'd2, 5'b00010}: bus.dec_char = 8'h41;
      {3'd3, 5'b00111}: bus.dec_char = 8'h53;
      {3'd5, 5'b11111}: bus.dec_char = 8'h35;
      default:          bus.dec_char = 8'h00;
    endcase
  end

  int         step_cnt = 0;
  int         xfer_cnt = 0;
  logic [7:0] step_log = 8'h00;
  logic       bad_overlap = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.dec_step) begin
        step_cnt = step_cnt + 1;
        step_log = {step_log[6:0], bus.dec_in};
      end
      if (bus.char_valid && bus.char_ready) xfer_cnt = xfer_cnt + 1;
      if (bus.char_valid && (bus.dec_step || bus.dec_clear)) bad_overlap = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic press(input int cycles);
    key = 1'b1;
    repeat (cycles) @(negedge clk);
    key = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.char_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_xfer(input string tag);
    bus.char_ready = 1'b1;
    @(negedge clk);
    bus.char_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(bus.char_valid), 32'd0);
    chk({tag, " clear pulse"}, 32'(bus.dec_clear), 32'd1);
    @(negedge clk);
    chk({tag, " clear end"}, 32'(bus.dec_clear), 32'd0);
  endtask

  task automatic after_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, " clear pulse"}, 32'(bus.dec_clear), 32'd1);
    chk({tag, " valid"}, 32'(bus.char_valid), 32'd0);
    chk({tag, " step"}, 32'(bus.dec_step), 32'd0);
    @(negedge clk);
    chk({tag, " clear once"}, 32'(bus.dec_clear), 32'd0);
  endtask

  initial begin
    int  s0;
    int  x0;
    bit  seen;

    key            = 1'b0;
    bus.char_ready = 1'b0;
    rst_n          = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset dec_clear", 32'(bus.dec_clear), 32'd0);
    chk("reset dec_step", 32'(bus.dec_step), 32'd0);
    chk("reset char_valid", 32'(bus.char_valid), 32'd0);
    chk("reset char_data", 32'(bus.char_data), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    after_reset("release");

    // Letter E: single dot.
    s0 = step_cnt;
    press(8);
    wait_valid(60, seen);
    chk("E valid", 32'(seen), 32'd1);
    chk("E steps", 32'(step_cnt - s0), 32'd1);
    chk("E dec_in", 32'(step_log[0]), 32'd1);
    chk("E data", 32'(bus.char_data), 32'h45);
    do_xfer("E xfer");

    // Letter A: dot, dash.
    s0 = step_cnt;
    press(8);
    repeat (8) @(negedge clk);
    press(20);
    wait_valid(60, seen);
    chk("A valid", 32'(seen), 32'd1);
    chk("A steps", 32'(step_cnt - s0), 32'd2);
    chk("A dec_in seq", 32'(step_log[1:0]), 32'd2);
    chk("A data", 32'(bus.char_data), 32'h41);

    // Backpressure with key activity while the letter is held.
    s0 = step_cnt;
    x0 = xfer_cnt;
    for (int i = 0; i < 50; i++) begin
      key = ((i % 3) == 0);
      @(negedge clk);
    end
    key = 1'b0;
    chk("hold valid", 32'(bus.char_valid), 32'd1);
    chk("hold data", 32'(bus.char_data), 32'h41);
    chk("hold no step", 32'(step_cnt - s0), 32'd0);
    chk("hold no xfer", 32'(xfer_cnt - x0), 32'd0);
    do_xfer("A xfer");
    chk("A one xfer", 32'(xfer_cnt - x0), 32'd1);

    // Six dots: overflow discards the letter.
    s0 = step_cnt;
    for (int i = 0; i < 6; i++) begin
      press(8);
      repeat (8) @(negedge clk);
    end
    wait_valid(60, seen);
    chk("ovf no valid", 32'(seen), 32'd0);
    chk("ovf steps", 32'(step_cnt - s0), 32'd5);
    chk("ovf dec_in", 32'(step_log[4:0]), 32'h1f);
`ifdef MORSE_CTRL_ERR_CNT_EN
    chk("ovf err_count", 32'(err_count), 32'd1);
`endif

    // Sub-tick glitch.
    s0 = step_cnt;
    press(2);
    repeat (4) @(negedge clk);
    chk("glitch idle", 32'(dut.state_q), 32'(StIdle));
    chk("glitch no step", 32'(step_cnt - s0), 32'd0);
    wait_valid(40, seen);
    chk("glitch no valid", 32'(seen), 32'd0);

    // Reset in the middle of a press.
    key = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    key = 1'b0;
    chk("rst press state", 32'(dut.state_q), 32'(StClear));
    chk("rst press step", 32'(bus.dec_step), 32'd0);
    chk("rst press clear", 32'(bus.dec_clear), 32'd0);
    after_reset("rst press");
    s0 = step_cnt;
    press(8);
    wait_valid(60, seen);
    chk("E2 valid", 32'(seen), 32'd1);
    chk("E2 data", 32'(bus.char_data), 32'h45);
    chk("E2 steps", 32'(step_cnt - s0), 32'd1);

    // Reset while the letter waits in OUT.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst out valid", 32'(bus.char_valid), 32'd0);
    chk("rst out data", 32'(bus.char_data), 32'd0);
    chk("rst out clear", 32'(bus.dec_clear), 32'd0);
    after_reset("rst out");
    s0 = step_cnt;
    press(20);
    wait_valid(60, seen);
    chk("T valid", 32'(seen), 32'd1);
    chk("T data", 32'(bus.char_data), 32'h54);
    chk("T steps", 32'(step_cnt - s0), 32'd1);
    chk("T dec_in", 32'(step_log[0]), 32'd0);
    do_xfer("T xfer");

    chk("valid overlap", 32'(bad_overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
